// File: rtl/counter_stim_gen_pkg.sv
// Shared encodings for the counter stimulus generator: phase codes, LFSR
// constants and small helpers used by the generator and its LFSR.
package counter_stim_gen_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CLEAR  = 4'd1,
        ST_LOAD   = 4'd2,
        ST_UP     = 4'd3,
        ST_HOLD   = 4'd4,
        ST_DOWN   = 4'd5,
        ST_PRIO   = 4'd6,
        ST_RANDOM = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Galois step, shifting right; the mask is folded in when bit 0 falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v, input logic [15:0] mask);
        return {1'b0, v[15:1]} ^ (v[0] ? mask : 16'h0000);
    endfunction

    function automatic state_t next_phase(input state_t s);
        case (s)
            ST_CLEAR:  return ST_LOAD;
            ST_LOAD:   return ST_UP;
            ST_UP:     return ST_HOLD;
            ST_HOLD:   return ST_DOWN;
            ST_DOWN:   return ST_PRIO;
            ST_PRIO:   return ST_RANDOM;
            ST_RANDOM: return ST_DONE;
            ST_DONE:   return ST_DONE;
            default:   return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/stim_lfsr16.sv
// 16-bit Galois LFSR with seed load and advance enable, shared by stimulus
// generators; a zero seed is replaced so the register never locks up.
module stim_lfsr16
    import counter_stim_gen_pkg::*;
#(
    parameter logic [15:0] MASK       = LFSR_MASK,
    parameter logic [15:0] RESET_SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_seed,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] value
);

    localparam logic [15:0] SAFE_RESET = (RESET_SEED == 16'h0000) ? DEFAULT_SEED : RESET_SEED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SAFE_RESET;
        end else if (load_seed) begin
            value <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
        end else if (advance) begin
            value <= lfsr_step(value, MASK);
        end
    end

endmodule

// File: rtl/counter_stim_gen.sv
// Directed-then-random stimulus generator for the N-bit up/down counter.
// Outputs are registered from the next-state decode so they line up with phase.
module counter_stim_gen
    import counter_stim_gen_pkg::*;
#(
    parameter int          N           = 3,
    parameter int          LOAD_VAL    = 5,
    parameter int          HOLD_CYCLES = 4,
    parameter int          RAND_CYCLES = 32,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    output logic         syn_clr,
    output logic         load,
    output logic         en,
    output logic         up,
    output logic [N-1:0] d,
    output logic [3:0]   phase,
    output logic         busy,
    output logic         done
);

    localparam int          SPAN      = (1 << N) + 1;
    localparam int          CNT_MAX   = max3(SPAN, HOLD_CYCLES, RAND_CYCLES);
    localparam int          CW        = $clog2(CNT_MAX + 1);
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
    localparam logic [31:0] LOAD_WORD = 32'(LOAD_VAL);

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   next_count;
    logic            seed_load;
    logic            lfsr_advance;
    logic [15:0]     lfsr_value;
    logic            unused_lfsr_bits;

    logic            syn_clr_next;
    logic            load_next;
    logic            en_next;
    logic            up_next;
    logic [N-1:0]    d_next;
    logic            busy_next;
    logic            done_next;

    // Cycles remaining after the first one spent in a state.
    function automatic logic [CW-1:0] span_of(input state_t s);
        case (s)
            ST_UP, ST_DOWN: return CW'(SPAN - 1);
            ST_HOLD:        return CW'(HOLD_CYCLES - 1);
            ST_RANDOM:      return CW'(RAND_CYCLES - 1);
            default:        return '0;
        endcase
    endfunction

    stim_lfsr16 #(
        .MASK       (LFSR_MASK),
        .RESET_SEED (SEED_EFF)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_seed (seed_load),
        .seed      (SEED_EFF),
        .advance   (lfsr_advance),
        .value     (lfsr_value)
    );

    assign unused_lfsr_bits = ^lfsr_value;
    assign phase            = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            syn_clr <= 1'b0;
            load    <= 1'b0;
            en      <= 1'b0;
            up      <= 1'b0;
            d       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= next_state;
            count   <= next_count;
            syn_clr <= syn_clr_next;
            load    <= load_next;
            en      <= en_next;
            up      <= up_next;
            d       <= d_next;
            busy    <= busy_next;
            done    <= done_next;
        end
    end

    // Outputs are decoded from the state being entered, so the LFSR value seen
    // here is the one that belongs to the coming RANDOM cycle.
    always_comb begin
        next_state   = state;
        next_count   = count;
        seed_load    = 1'b0;
        syn_clr_next = 1'b0;
        load_next    = 1'b0;
        en_next      = 1'b0;
        up_next      = 1'b0;
        d_next       = '0;

        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) next_state = ST_CLEAR;
                end
                ST_DONE: begin
                    if (start) begin
                        next_state = ST_CLEAR;
                        seed_load  = 1'b1;
                    end
                end
                default: begin
                    if (count == '0) next_state = next_phase(state);
                end
            endcase
        end

        if (next_state != state) begin
            next_count = span_of(next_state);
        end else if (count != '0) begin
            next_count = count - CW'(1);
        end

        lfsr_advance = (next_state == ST_RANDOM);

        case (next_state)
            ST_CLEAR: syn_clr_next = 1'b1;
            ST_LOAD: begin
                load_next = 1'b1;
                d_next    = LOAD_WORD[N-1:0];
            end
            ST_UP: begin
                en_next = 1'b1;
                up_next = 1'b1;
            end
            ST_DOWN: en_next = 1'b1;
            ST_PRIO: begin
                syn_clr_next = 1'b1;
                load_next    = 1'b1;
                en_next      = 1'b1;
                up_next      = 1'b1;
                d_next       = '1;
            end
            ST_RANDOM: begin
                syn_clr_next = (lfsr_value[15:12] == 4'h0);
                load_next    = (lfsr_value[11:9] == 3'h0);
                en_next      = lfsr_value[8];
                up_next      = lfsr_value[7];
                d_next       = lfsr_value[N-1:0];
            end
            default: ;
        endcase

        busy_next = (next_state != ST_IDLE) && (next_state != ST_DONE);
        done_next = (next_state == ST_DONE);
    end

endmodule

// File: tb/tb_counter_stim_gen.sv
// Self-checking bench for counter_stim_gen: directed steps push expected
// outputs into a scoreboard that is popped after each rising edge.
module tb_counter_stim_gen;

    localparam int N = 3;

    localparam logic [3:0] PH_IDLE   = 4'd0;
    localparam logic [3:0] PH_CLEAR  = 4'd1;
    localparam logic [3:0] PH_LOAD   = 4'd2;
    localparam logic [3:0] PH_UP     = 4'd3;
    localparam logic [3:0] PH_HOLD   = 4'd4;
    localparam logic [3:0] PH_DOWN   = 4'd5;
    localparam logic [3:0] PH_PRIO   = 4'd6;
    localparam logic [3:0] PH_RANDOM = 4'd7;
    localparam logic [3:0] PH_DONE   = 4'd8;

    typedef struct packed {
        logic [3:0]   phase;
        logic         syn_clr;
        logic         load;
        logic         en;
        logic         up;
        logic [N-1:0] d;
        logic         busy;
        logic         done;
    } obs_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         syn_clr;
    logic         load;
    logic         en;
    logic         up;
    logic [N-1:0] d;
    logic [3:0]   phase;
    logic         busy;
    logic         done;

    obs_t         observed;
    obs_t         scoreboard[$];
    logic [15:0]  model_lfsr = 16'hACE1;
    int           checks     = 0;
    int           failures   = 0;

    counter_stim_gen #(
        .N           (N),
        .LOAD_VAL    (5),
        .HOLD_CYCLES (4),
        .RAND_CYCLES (32),
        .SEED        (16'hACE1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .syn_clr (syn_clr),
        .load    (load),
        .en      (en),
        .up      (up),
        .d       (d),
        .phase   (phase),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    assign observed = {phase, syn_clr, load, en, up, d, busy, done};

    function automatic logic [15:0] modelStep(input logic [15:0] l);
        logic [15:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic obs_t modelOut(input logic [3:0] ph, input logic [15:0] l);
        obs_t e;
        e = '0;
        e.phase = ph;
        case (ph)
            PH_CLEAR: e.syn_clr = 1'b1;
            PH_LOAD: begin
                e.load = 1'b1;
                e.d    = 3'd5;
            end
            PH_UP: begin
                e.en = 1'b1;
                e.up = 1'b1;
            end
            PH_DOWN: e.en = 1'b1;
            PH_PRIO: begin
                e.syn_clr = 1'b1;
                e.load    = 1'b1;
                e.en      = 1'b1;
                e.up      = 1'b1;
                e.d       = 3'b111;
            end
            PH_RANDOM: begin
                e.syn_clr = (l[15:12] == 4'h0);
                e.load    = (l[11:9] == 3'h0);
                e.en      = l[8];
                e.up      = l[7];
                e.d       = l[2:0];
            end
            PH_DONE: e.done = 1'b1;
            default: ;
        endcase
        e.busy = (ph != PH_IDLE) && (ph != PH_DONE);
        return e;
    endfunction

    task automatic applyStimulus(input logic s, input logic a, input logic [3:0] ph);
        obs_t e;
        @(negedge clk);
        start = s;
        abort = a;
        e = modelOut(ph, model_lfsr);
        if (ph == PH_RANDOM) model_lfsr = modelStep(model_lfsr);
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        obs_t e;
        @(posedge clk);
        #1;
        e = scoreboard.pop_front();
        checks++;
        assert (observed === e) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, e);
        end
    endtask

    task automatic step(input logic s, input logic a, input logic [3:0] ph, input string tag);
        applyStimulus(s, a, ph);
        checkOutput(tag);
    endtask

    // A full run from IDLE or DONE; a start pulse during HOLD must be ignored.
    task automatic runFull(input string tag);
        step(1'b1, 1'b0, PH_CLEAR, {tag, "_clear"});
        step(1'b0, 1'b0, PH_LOAD, {tag, "_load"});
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, PH_UP, {tag, "_up"});
        for (int i = 0; i < 4; i++) step(i == 1, 1'b0, PH_HOLD, {tag, "_hold"});
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, PH_DOWN, {tag, "_down"});
        step(1'b0, 1'b0, PH_PRIO, {tag, "_prio"});
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, PH_RANDOM, {tag, "_random"});
            if (i == 0) begin
                checks++;
                assert ({syn_clr, load, en, up, d} === 7'b0001001) else begin
                    failures++;
                    $error("[TB] FAIL %s_rand0: observed %b expected %b", tag, {syn_clr, load, en, up, d}, 7'b0001001);
                end
            end else if (i == 1) begin
                checks++;
                assert ({syn_clr, load, en, up, d} === 7'b0000000) else begin
                    failures++;
                    $error("[TB] FAIL %s_rand1: observed %b expected %b", tag, {syn_clr, load, en, up, d}, 7'b0000000);
                end
            end
        end
        step(1'b0, 1'b0, PH_DONE, {tag, "_done"});
        step(1'b0, 1'b0, PH_DONE, {tag, "_done_stay"});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert (observed === '0) else begin
            failures++;
            $error("[TB] FAIL reset_hold: observed %h expected %h", observed, 13'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_lfsr = 16'hACE1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, PH_IDLE, "idle");

        $display("[TB] first run from IDLE");
        runFull("run1");

        $display("[TB] second run from DONE, LFSR re-seeded");
        model_lfsr = 16'hACE1;
        runFull("run2");

        $display("[TB] abort during third UP cycle");
        model_lfsr = 16'hACE1;
        step(1'b1, 1'b0, PH_CLEAR, "ab_clear");
        step(1'b0, 1'b0, PH_LOAD, "ab_load");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, PH_UP, "ab_up");
        step(1'b0, 1'b1, PH_IDLE, "abort");
        step(1'b0, 1'b0, PH_IDLE, "after_abort");
        step(1'b1, 1'b0, PH_CLEAR, "restart_clear");
        step(1'b0, 1'b0, PH_LOAD, "restart_load");
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, PH_UP, "restart_up");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, PH_HOLD, "restart_hold");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, PH_DOWN, "restart_down");

        $display("[TB] asynchronous reset during DOWN");
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        assert (observed === '0) else begin
            failures++;
            $error("[TB] FAIL async_reset: observed %h expected %h", observed, 13'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_lfsr = 16'hACE1;
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, PH_IDLE, "post_reset_idle");
        step(1'b1, 1'b0, PH_CLEAR, "post_reset_clear");
        step(1'b0, 1'b0, PH_LOAD, "post_reset_load");
        step(1'b0, 1'b1, PH_IDLE, "post_reset_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_stim_gen.md
Name: counter_stim_gen

Overview:
Synthesizable stimulus generator that drives the control inputs (syn_clr, load, en, up, d) of the N-bit enhanced up/down binary counter. It is the driving end of the counter's control interface; the counter monitor is the observing end. It runs a fixed directed sequence (clear, load, count up through wrap, hold, count down through wrap, priority collision), then an LFSR-driven random phase. It then reports done, so counter, generator and monitor can run together on the board or in simulation.

Parameters:
N, 3, counter width; legal range 1..7.
LOAD_VAL, 5, value driven on d during the LOAD phase (lower N bits used).
HOLD_CYCLES, 4, cycles of en=0 in the HOLD phase; must be >=1.
RAND_CYCLES, 32, cycles in the RANDOM phase; must be >=1.
SEED, 16'hACE1, LFSR seed; 0 is replaced by 16'hACE1.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sequence; sampled only in IDLE or DONE
abort  in  1  synchronous return to IDLE; has priority over start
syn_clr  out  1  to counter: synchronous clear
load  out  1  to counter: parallel load
en  out  1  to counter: count enable
up  out  1  to counter: direction, 1 = up
d  out  N  to counter: load data
phase  out  4  current state code (see Behaviour)
busy  out  1  high in every state except IDLE and DONE
done  out  1  high while in DONE

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- All outputs are registered. On reset: state=IDLE, all outputs 0, LFSR=SEED (0 is replaced by ACE1).
- State codes on phase: IDLE=0, CLEAR=1, LOAD=2, UP=3, HOLD=4, DOWN=5, PRIO=6, RANDOM=7, DONE=8.
- Latency: start=1 in IDLE or DONE at edge k. CLEAR outputs are visible after edge k+1, i.e. the next cycle. Each state's outputs are valid for the whole time phase shows that state.
- CLEAR, 1 cycle: syn_clr=1, all other outputs 0.
- LOAD, 1 cycle: load=1, d=LOAD_VAL.
- UP, 2^N+1 cycles: en=1, up=1, d=0. Guarantees one wrap max->0.
- HOLD, HOLD_CYCLES cycles: all controls 0.
- DOWN, 2^N+1 cycles: en=1, up=0. Guarantees one wrap 0->max.
- PRIO, 1 cycle: syn_clr=1, load=1, en=1, up=1, d=all ones. The counter must clear, since clear has priority.
- RANDOM, RAND_CYCLES cycles. Each cycle's controls are decoded from the current LFSR value L:
  - syn_clr = (L[15:12]==0)
  - load = (L[11:9]==0)
  - en = L[8]
  - up = L[7]
  - d = L[N-1:0]
- LFSR: 16-bit Galois, right shift. Feedback XOR mask 16'hB400 is applied when the shifted-out bit L[0]=1. It advances once per RANDOM cycle only. Example: ACE1 -> E270.
- DONE: all controls 0, done=1.
  - start in DONE: re-seed the LFSR to SEED and go to CLEAR. The sequence is repeatable.
  - Otherwise stay in DONE.
- Cycle counter: width enough for max(2^N+1, HOLD_CYCLES, RAND_CYCLES). It is loaded on each state entry and decremented each cycle; the state exits on the cycle it reaches the terminal count.
- abort=1 in any state: next cycle state=IDLE, all controls 0, busy=0, done=0. The LFSR is not re-seeded.
- start while busy: ignored.
- rst_n low mid-sequence: immediate return to IDLE with all outputs 0.
- Total busy length = 1 + 1 + (2^N+1) + HOLD_CYCLES + (2^N+1) + 1 + RAND_CYCLES. This is 57 cycles at the defaults.

Decomposition:
- Shared package: state encoding constants (phase codes 0..8), LFSR mask 16'hB400, default seed 16'hACE1.
- One sub-module: stim_lfsr16. Ports: clk, rst_n, load_seed, seed, advance, value. It is reusable by other stimulus generators.
- The FSM, cycle counter and output decode stay in counter_stim_gen.

Test Plan:
- Reset held, then released; no start → all outputs 0, phase=0, busy=0, done=0.
- Defaults, start pulse at edge 0 → after edge 1 syn_clr=1 and phase=1. After edge 2 load=1, d=5. Then 9 cycles of en=1, up=1 (counter 5->6 wrapping), 4 hold cycles, 9 down cycles, 1 PRIO cycle with all controls 1 and d=7, 32 random cycles. done=1 after edge 58. With the real counter and monitor attached, no ERROR is reported.
- First two RANDOM cycles → (syn_clr, load, en, up, d) = (0, 0, 0, 1, 001), then (0, 0, 0, 0, 000).
- abort asserted mid-UP (3rd UP cycle) → next cycle phase=0 and all controls 0. A subsequent start produces CLEAR after one cycle.
- rst_n driven low asynchronously mid-DOWN → outputs go to 0 without waiting for a clock edge; phase=0.
- start in DONE (twice) → second run's RANDOM outputs are identical to the first run's (LFSR re-seeded). start pulsed while busy → no effect on the phase sequence.
